demux12_buf: RTL and testbench

Buffered 1-to-2 steering block: the inverse of the CPU's 2:1 operand/result select. Accepts one 32-bit word per cycle on a valid/ready input and routes it to output port A (`in_sel`=0) or port B (`in_sel`=1). Each port has its own small FIFO, so one stalled consumer never corrupts the other port's ordering. Sits between the execute stage and its two consumers, for example register writeback and the memory store path.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux12_buf_fifo_buf.sv | 66 ++++++
 rtl/demux12_buf.sv | 73 +++++++
 tb/tb_demux12_buf.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-2 buffered demux
package demux_pkg;

  localparam int   WIDTH_DEFAULT = 32;
  localparam int   COUNT_W       = 16;
  localparam logic SEL_A         = 1'b0;
  localparam logic SEL_B         = 1'b1;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/demux12_buf_fifo_buf.sv
// rtl/demux12_buf_fifo_buf.sv - small register FIFO with registered full/empty flags
module fifo_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_occ;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_occ_next;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = push & ~r_full;
  assign w_pop  = pop & ~r_empty;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + 1'b1;
      2'b01:   w_occ_next = r_occ - 1'b1;
      default: w_occ_next = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == (PTR_W+1)'(DEPTH));
      r_empty <= (w_occ_next == '0);
    end
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/demux12_buf.sv
// rtl/demux12_buf.sv - steers one input stream into two independently buffered output ports
module demux12_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_sel,
  output logic               a_valid,
  input  logic               a_ready,
  output logic [WIDTH-1:0]   a_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [WIDTH-1:0]   b_data,
  output logic [COUNT_W-1:0] a_count,
  output logic [COUNT_W-1:0] b_count
);

  logic   w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic   w_push_a, w_push_b, w_pop_a, w_pop_b;
  count_t r_a_count, r_b_count;

  // Only registered full flags feed in_ready, so consumer readies never reach it.
  assign in_ready = (in_sel == SEL_B) ? ~w_b_full : ~w_a_full;

  assign w_push_a = in_valid & in_ready & (in_sel == SEL_A);
  assign w_push_b = in_valid & in_ready & (in_sel == SEL_B);
  assign w_pop_a  = ~w_a_empty & a_ready;
  assign w_pop_b  = ~w_b_empty & b_ready;

  fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_a),
    .push_data (in_data),
    .pop       (w_pop_a),
    .full      (w_a_full),
    .empty     (w_a_empty),
    .head      (a_data)
  );

  fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_b),
    .push_data (in_data),
    .pop       (w_pop_b),
    .full      (w_b_full),
    .empty     (w_b_empty),
    .head      (b_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_pop_a) r_a_count <= r_a_count + 1'b1;
      if (w_pop_b) r_b_count <= r_b_count + 1'b1;
    end
  end

  assign a_valid = ~w_a_empty;
  assign b_valid = ~w_b_empty;
  assign a_count = r_a_count;
  assign b_count = r_b_count;

endmodule

// File: tb/tb_demux12_buf.sv
// tb/tb_demux12_buf.sv - self-checking bench for demux12_buf against a queue-based model
module tb_demux12_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        a_valid, a_ready;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [31:0] b_data;
  logic [15:0] a_count, b_count;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] cnt_a, cnt_b;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  demux12_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against the model, advance the model by the handshakes.
  task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                       input logic ar, input logic br, output logic acc);
    logic exp_rdy;
    in_valid = v; in_sel = sel; in_data = d; a_ready = ar; b_ready = br;
    #1;
    exp_rdy = sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    check("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) check("a_data", a_data, qa[0]);
    if (qb.size() != 0) check("b_data", b_data, qb[0]);
    check("a_count", 32'(a_count), 32'(cnt_a));
    check("b_count", 32'(b_count), 32'(cnt_b));
    acc = v & exp_rdy;
    if (ar && qa.size() != 0) begin void'(qa.pop_front()); cnt_a = cnt_a + 16'd1; end
    if (br && qb.size() != 0) begin void'(qb.pop_front()); cnt_b = cnt_b + 16'd1; end
    if (acc) begin
      if (sel) qb.push_back(d);
      else     qa.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic v);
    rst_n = 1'b0; in_valid = v; in_sel = 1'($urandom); in_data = $urandom;
    a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    qa.delete(); qb.delete();
    cnt_a = '0; cnt_b = '0;
  endtask

  initial begin
    logic        acc;
    logic        pv, ps;
    logic [31:0] pd;
    int          n_acc;

    in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    cnt_a = '0; cnt_b = '0;
    pv = 1'b0; ps = 1'b0; pd = '0;
    do_reset(1'b0);

    // Reset state after one idle cycle
    check("rst_a_data", a_data, 32'h0);
    check("rst_b_data", b_data, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);

    // One word to each port
    cycle(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, acc);
    cycle(1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, acc);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
    check("t2_a_count", 32'(a_count), 32'd1);
    check("t2_b_count", 32'(b_count), 32'd1);

    // A stalled: third word must wait for a slot
    cycle(1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b0, 32'hA2, 1'b0, 1'b1, acc);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, acc);
    check("t3_ready_after_pop", 32'(in_ready), 32'd1);
    check("t3_head_a1", a_data, 32'hA1);
    cycle(1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, acc);
    check("t3_head_a2", a_data, 32'hA2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
    check("t3_a_count", 32'(a_count), 32'd4);

    // A full and stalled while B keeps flowing
    cycle(1'b1, 1'b0, 32'hC0, 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b0, 32'hC1, 1'b0, 1'b1, acc);
    cycle(1'b1, 1'b1, 32'hB5, 1'b0, 1'b1, acc);
    check("t4_b_head", b_data, 32'hB5);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    check("t4_a_head", a_data, 32'hC0);
    check("t4_a_valid", 32'(a_valid), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

    // Long B stream wraps the 16-bit counter
    do_reset(1'b0);
    n_acc = 0;
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1, acc);
      if (acc) n_acc++;
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    check("stream_accepted", 32'(n_acc), 32'd70000);
    check("stream_b_count", 32'(b_count), 32'd4464);

    // Randomized traffic; a rejected word is held until accepted
    for (int i = 0; i < 3000; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 1'($urandom);
        pd = $urandom;
      end
      cycle(pv, ps, pd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, acc);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

    // Fill both, then reset with a word offered: everything flushed
    cycle(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 32'hD1, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'hE0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 32'hE1, 1'b0, 1'b0, acc);
    do_reset(1'b1);
    in_valid = 1'b0;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_a_valid", 32'(a_valid), 32'd0);
    check("flush_b_valid", 32'(b_valid), 32'd0);
    check("flush_a_count", 32'(a_count), 32'd0);
    check("flush_b_count", 32'(b_count), 32'd0);
    check("flush_a_data", a_data, 32'h0);
    check("flush_b_data", b_data, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
